// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter sharing one registered fp16 multiplier among N_REQ requesters,
// with an ID-tag pipeline and credit-protected response FIFO. Optional counters: FP16_ARB_PERF_EN.
module fp16_mul_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MUL_LAT    = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [16*N_REQ-1:0]  req_a,
  input  logic [16*N_REQ-1:0]  req_b,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 busy
`ifdef FP16_ARB_PERF_EN
  ,
  output logic [31:0]          issue_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  // Tag stage 0 sits beside mul_a/mul_b; stage MUL_LAT sits beside mul_p.
  localparam int NS = MUL_LAT + 1;

  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  logic [15:0]     a_arr [N_REQ];
  logic [15:0]     b_arr [N_REQ];
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_found;
  logic            credit_ok;
  logic            issue;

  logic [NS-1:0]   vld_p;
  logic [IDW-1:0]  id_p [NS];

  logic [IDW-1:0]  mem_id   [FIFO_DEPTH];
  logic [15:0]     mem_data [FIFO_DEPTH];
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   remain;
  logic [CW-1:0]   cnt_nxt;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_nxt;
  logic            push;
  logic            pop;
  logic [IDW-1:0]  head_id;
  logic [15:0]     head_data;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[16*i +: 16];
    assign b_arr[i] = req_b[16*i +: 16];
  end

  // Pops in the same cycle are deliberately not credited back.
  assign credit_ok = (int'(fifo_cnt) + $countones(vld_p)) < FIFO_DEPTH;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign issue     = gnt_found & credit_ok;
  assign req_ready = issue ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;

  // ---- stage p0: operand register and tag pipeline entry ----
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ptr   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      vld_p <= '0;
    end else begin
      vld_p <= {vld_p[NS-2:0], issue};
      if (issue) begin
        mul_a <= a_arr[gnt_idx];
        mul_b <= b_arr[gnt_idx];
        ptr   <= rr_next(gnt_idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    id_p[0] <= gnt_idx;
    for (int s = 1; s < NS; s++) id_p[s] <= id_p[s-1];
  end

  // ---- stage p(MUL_LAT): product capture into the response FIFO ----
  assign push = vld_p[NS-1];
  assign pop  = rsp_valid & rsp_ready;

  always_comb begin
    rd_nxt  = pop ? fifo_inc(rd_ptr) : rd_ptr;
    remain  = fifo_cnt - CW'(pop);
    cnt_nxt = remain + CW'(push);
    if (remain == '0) begin
      head_id   = id_p[NS-1];
      head_data = mul_p;
    end else begin
      head_id   = mem_id[rd_nxt];
      head_data = mem_data[rd_nxt];
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_id[wr_ptr]   <= id_p[NS-1];
      mem_data[wr_ptr] <= mul_p;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      fifo_cnt  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      fifo_cnt  <= cnt_nxt;
      rd_ptr    <= rd_nxt;
      rsp_valid <= (cnt_nxt != '0);
      if (push) wr_ptr <= fifo_inc(wr_ptr);
      if (cnt_nxt != '0) begin
        rsp_id   <= head_id;
        rsp_data <= head_data;
      end
    end
  end

  assign busy = (|vld_p) | (fifo_cnt != '0);

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RESETn)
    !(push && (fifo_cnt == CW'(FIFO_DEPTH))));

`ifdef FP16_ARB_PERF_EN
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + 32'd1;
      if ((|req_valid) && !credit_ok) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Scoreboard bench for fp16_mul_arbiter with a registered stand-in multiplier.
module tb_fp16_mul_arbiter;

  localparam int N = 4;

  logic            CLK = 1'b0;
  logic            RESETn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [15:0]     mul_a;
  logic [15:0]     mul_b;
  logic [15:0]     mul_p;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_data;
  logic            busy;
`ifdef FP16_ARB_PERF_EN
  logic [31:0]     issue_cnt;
  logic [31:0]     stall_cnt;
`endif

  logic [17:0] sb[$];
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  fp16_mul_arbiter #(.N_REQ(N), .MUL_LAT(1), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
`ifdef FP16_ARB_PERF_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Stand-in for the external multiplier; the test-plan operand pairs are pinned.
  function automatic logic [15:0] mul_model(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return 16'h4000;
      32'h7C00_0000: return 16'h7C01;
      32'hC000_3800: return 16'hBC00;
      default:       return a ^ {b[7:0], b[15:8]} ^ 16'h5A5A;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) mul_p <= '0;
    else         mul_p <= mul_model(mul_a, mul_b);
  end

  // Scoreboard: push on each handshake, pop on each response accepted.
  always @(negedge CLK) begin
    if (RESETn === 1'b1) begin
      if (req_ready != '0) begin
        checks++;
        if (!$onehot(req_ready) || ((req_ready & ~req_valid) != '0)) begin
          errors++;
          $display("FAIL grant_onehot req_ready=%b req_valid=%b", req_ready, req_valid);
        end
        for (int i = 0; i < N; i++)
          if (req_ready[i]) sb.push_back({2'(i), mul_model(req_a[16*i +: 16], req_b[16*i +: 16])});
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got id=%0d data=%h, expected no response", rsp_id, rsp_data);
        end else begin
          logic [17:0] exp;
          exp = sb.pop_front();
          if ({rsp_id, rsp_data} !== exp) begin
            errors++;
            $display("FAIL rsp_order got id=%0d data=%h, expected id=%0d data=%h",
                     rsp_id, rsp_data, exp[17:16], exp[15:0]);
          end
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic rand_ops;
    for (int i = 0; i < N; i++) set_op(i, 16'($urandom), 16'($urandom));
  endtask

  task automatic do_reset;
    RESETn    = 1'b0;
    sb.delete();
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge CLK); #1;
    RESETn = 1'b1;
  endtask

  task automatic wait_idle;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (!busy && sb.size() == 0) break;
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    RESETn = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      errors++;
      $display("FAIL reset_values got mul_a=%h mul_b=%h rsp_valid=%b rsp_id=%0d rsp_data=%h busy=%b, expected all 0",
               mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy);
    end
`ifdef FP16_ARB_PERF_EN
    checks++;
    if (issue_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters got issue=%0d stall=%0d, expected 0 0", issue_cnt, stall_cnt);
    end
`endif
    RESETn = 1'b1;
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release got rsp_valid=%b busy=%b req_ready=%b, expected 0 0 0000",
               rsp_valid, busy, req_ready);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_single;
    do_reset;
    rsp_ready = 1'b1;
    set_op(2, 16'h3C00, 16'h4000);
    req_valid = 4'b0100;
    @(negedge CLK);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant got %b, expected 0100", req_ready);
    end
    @(posedge CLK); #1;
    req_valid = '0;
    @(negedge CLK);
    checks++;
    if (mul_a !== 16'h3C00 || mul_b !== 16'h4000 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_operands got a=%h b=%h rsp_valid=%b, expected 3c00 4000 0", mul_a, mul_b, rsp_valid);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_early got rsp_valid=%b, expected 0", rsp_valid);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'h4000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp got valid=%b id=%0d data=%h busy=%b, expected 1 2 4000 1",
               rsp_valid, rsp_id, rsp_data, busy);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 16'h4000 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL single_after got valid=%b busy=%b id=%0d data=%h, expected 0 0 2 4000 (held)",
               rsp_valid, busy, rsp_id, rsp_data);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_fairness;
    do_reset;
    rsp_ready = 1'b1;
    rand_ops;
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (c % 4);
      @(negedge CLK);
      checks++;
      if (req_ready !== exp_g) begin
        errors++; $display("FAIL fair_grant cycle %0d got %b, expected %b", c, req_ready, exp_g);
      end
      @(posedge CLK); #1;
      rand_ops;
    end
    req_valid = '0;
    wait_idle;
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL fair_drain got busy=%b pending=%0d, expected 0 0", busy, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    int iss;
    do_reset;
    rand_ops;
    req_valid = 4'b1111;
    iss = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (req_ready != '0) iss++;
      @(posedge CLK); #1;
    end
    checks++;
    if (iss != 4) begin
      errors++; $display("FAIL bp_issues got %0d, expected 4", iss);
    end
    @(negedge CLK);
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stalled got req_ready=%b rsp_valid=%b, expected 0000 1", req_ready, rsp_valid);
    end
    @(posedge CLK); #1;
    rsp_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL bp_pop_not_credited got %b, expected 0000", req_ready);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_resume got %b, expected 0001", req_ready);
    end
    @(posedge CLK); #1;
    req_valid = '0;
    wait_idle;
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL bp_drain got busy=%b pending=%0d, expected 0 0", busy, sb.size());
    end
  endtask

  task automatic test_special;
    logic [15:0] ea [2];
    logic [15:0] eb [2];
    logic [15:0] ep [2];
    int          rq [2];
    ea[0] = 16'h7C00; eb[0] = 16'h0000; ep[0] = 16'h7C01; rq[0] = 1;
    ea[1] = 16'hC000; eb[1] = 16'h3800; ep[1] = 16'hBC00; rq[1] = 3;
    do_reset;
    rsp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      int n;
      set_op(rq[t], ea[t], eb[t]);
      req_valid = 4'b0001 << rq[t];
      @(posedge CLK); #1;
      req_valid = '0;
      n = 0;
      @(negedge CLK);
      while (!rsp_valid && n < 8) begin
        @(negedge CLK);
        n++;
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== ep[t] || rsp_id !== 2'(rq[t])) begin
        errors++;
        $display("FAIL special_%0d got valid=%b id=%0d data=%h, expected 1 %0d %h",
                 t, rsp_valid, rsp_id, rsp_data, rq[t], ep[t]);
      end
      @(posedge CLK); #1;
    end
    wait_idle;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL special_drain got pending=%0d, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_midflight;
    int stale;
    do_reset;
    rand_ops;
    req_valid = 4'b0111;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    req_valid = '0;
    @(posedge CLK); #1;
    checks++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got rsp_valid=%b busy=%b, expected 1 1", rsp_valid, busy);
    end
    RESETn = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      errors++;
      $display("FAIL midrst_values got mul_a=%h mul_b=%h rsp_valid=%b rsp_id=%0d rsp_data=%h busy=%b, expected all 0",
               mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy);
    end
    @(posedge CLK); #1;
    RESETn = 1'b1;
    rsp_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stale++;
      @(posedge CLK); #1;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL midrst_stale got %0d cycles with stale activity, expected 0", stale);
    end
    req_valid = 4'b1111;
    @(negedge CLK);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_first_grant got %b, expected 0001", req_ready);
    end
    @(posedge CLK); #1;
    req_valid = '0;
    wait_idle;
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL midrst_drain got busy=%b pending=%0d, expected 0 0", busy, sb.size());
    end
  endtask

`ifdef FP16_ARB_PERF_EN
  task automatic test_perf;
    int iss, stl, n;
    do_reset;
    rand_ops;
    req_valid = 4'b1111;
    iss = 0; stl = 0; n = 0;
    while (stl < 3 && n < 40) begin
      @(negedge CLK);
      if (req_ready != '0) iss++; else stl++;
      n++;
      @(posedge CLK); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle;
    req_valid = 4'b1111;
    while (iss < 10 && n < 80) begin
      @(negedge CLK);
      if (req_ready != '0) iss++; else stl++;
      n++;
      @(posedge CLK); #1;
    end
    req_valid = '0;
    checks++;
    if (issue_cnt !== 32'd10 || stall_cnt !== 32'd3) begin
      errors++; $display("FAIL perf_counts got issue=%0d stall=%0d, expected 10 3", issue_cnt, stall_cnt);
    end
    wait_idle;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_back_to_back;
    test_special;
    test_reset_midflight;
`ifdef FP16_ARB_PERF_EN
    test_perf;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
